mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the core's single memory bus between two requesters: instruction fetch (read-only) and load/store (read/write).
- Sits between the core's fetch and load/store paths and the external memory port.
- Keeps one transaction outstanding at a time.
- Fixed priority favours load/store; a starvation guard bounds how long fetch waits; a timeout aborts hung bus transactions.

Parameters:
STARVE_LIMIT, 4, consecutive waiting cycles after which fetch wins over load/store (must be >=1)
TIMEOUT, 255, max cycles mem_valid may stay high without mem_ready before abort; 0 disables

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
if_req  input  1  fetch request, held with if_addr until if_gnt
if_addr  input  32  fetch address
if_gnt  output  1  fetch request accepted (combinational, IDLE only)
if_rvalid  output  1  one-cycle fetch completion pulse
if_rdata  output  32  fetch data, valid with if_rvalid
if_err  output  1  fetch timed out, valid with if_rvalid
ls_req  input  1  load/store request, held with fields until ls_gnt
ls_we  input  1  1 = store
ls_addr  input  32  load/store address
ls_wdata  input  32  store data
ls_wstrb  input  4  store byte enables
ls_gnt  output  1  load/store request accepted
ls_rvalid  output  1  one-cycle completion pulse (loads and stores)
ls_rdata  output  32  load data, valid with ls_rvalid
ls_err  output  1  load/store timed out, valid with ls_rvalid
mem_valid  output  1  bus request, held until mem_ready
mem_we  output  1  bus write enable
mem_addr  output  32  bus address
mem_wdata  output  32  bus write data
mem_wstrb  output  4  bus byte enables
mem_ready  input  1  bus completes in the cycle it is high with mem_valid
mem_rdata  input  32  bus read data, valid with mem_ready

Behaviour:
- Reset (reset low, asynchronous): state IDLE; starvation and timeout counters 0; every output 0. A transaction in flight when reset asserts is dropped: mem_valid falls immediately and no rvalid is ever issued for it.
- States: IDLE, BUSY_IF, BUSY_LS.
- IDLE selection:
  - ls_req only -> ls_gnt.
  - if_req only -> if_gnt.
  - Both -> ls_gnt, unless starve_cnt == STARVE_LIMIT, then if_gnt.
  - Exactly one gnt is high, for one cycle.
- Grant edge:
  - Request fields are latched into bus registers.
  - Next state is BUSY_IF or BUSY_LS.
  - mem_valid rises on the cycle after gnt.
- Fetch drives mem_we=0 and mem_wstrb=0; address is forwarded unmodified (no alignment).
- No grant is issued in BUSY states; requesters keep req high.
- Completion (BUSY, mem_valid & mem_ready):
  - mem_rdata is registered into the owner's rdata (0 for stores).
  - The owner's rvalid pulses the next cycle with err=0.
  - mem_valid drops; state returns to IDLE.
  - Bus fields hold stable throughout BUSY.
- Minimum latency: gnt at cycle N, mem_valid at N+1, mem_ready at N+1 -> rvalid at N+2, next gnt possible at N+2. Peak throughput is one transaction per 2 cycles.
- Starvation counter:
  - Increments each cycle if_req & !if_gnt, saturating at STARVE_LIMIT.
  - Clears on if_gnt.
  - Also clears when if_req is low.
- Timeout counter:
  - Clears on entering BUSY; increments each BUSY cycle without mem_ready.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT: mem_valid drops, the owner's rvalid pulses next cycle with err=1 and rdata=0, state returns to IDLE.
  - mem_ready in the same cycle as the limit -> normal completion wins (err=0).
- if_rvalid and ls_rvalid are never high in the same cycle.
- mem_ready while not BUSY is ignored.

Decomposition:
- core_pkg holds:
  - Arbiter state encoding (IDLE/BUSY_IF/BUSY_LS).
  - Requester id constants (REQ_IF, REQ_LS).
  - Bus width constants (XLEN=32, STRB_W=4).
- One sub-module, arb_select:
  - Combinational priority choice plus the saturating starvation counter.
  - Outputs the grant vector.
- mem_arbiter keeps the FSM, bus registers, timeout counter and response routing.

Test Plan:
1. Reset mid-transaction: ls load granted, mem_valid=1, reset pulled low -> mem_valid=0 immediately; no ls_rvalid after release; all outputs 0.
2. Single fetch: if_req, if_addr=0x0000_0100, mem_ready on first mem_valid cycle, mem_rdata=0x0000_0013 -> if_gnt cycle 0, mem_valid cycle 1, if_rvalid cycle 2 with if_rdata=0x13, if_err=0.
3. Priority: if_req and ls_req both high with ls_we=1, ls_addr=0x2000, ls_wdata=0xDEAD_BEEF, ls_wstrb=0xF -> ls granted first; bus shows mem_we=1, wstrb=0xF; fetch granted after ls_rvalid.
4. Starvation: ls_req held high continuously, if_req high, STARVE_LIMIT=4, mem_ready always 1 -> if_gnt occurs once the counter reaches 4; the counter clears on that grant.
5. Timeout: TIMEOUT=8, ls load issued, mem_ready never asserted -> mem_valid high exactly 8 cycles, then ls_rvalid=1, ls_err=1, ls_rdata=0; state returns to IDLE.
6. Race: TIMEOUT=8, mem_ready asserted on the 8th BUSY cycle with mem_rdata=0x55 -> normal completion, ls_err=0, ls_rdata=0x55.

Source files
------------

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types and constants for the memory arbiter
//
// Purpose: arbiter state encoding, requester ids and bus widths used by
// mem_arbiter and arb_select.
// Ports: none (package).
package core_pkg;

    localparam int XLEN   = 32;
    localparam int STRB_W = 4;

    // Requester ids double as bit positions in the grant vector.
    localparam int REQ_IF = 0;
    localparam int REQ_LS = 1;
    localparam int N_REQ  = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_select.sv
// rtl/arb_select.sv - fixed-priority requester select with fetch starvation guard
//
// Purpose: picks which requester is granted while the arbiter is idle.
// Load/store wins by default; fetch wins once it has waited STARVE_LIMIT
// consecutive cycles.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   idle         arbiter may grant this cycle
//   if_req       fetch request
//   ls_req       load/store request
//   gnt          one-hot grant vector, indexed by REQ_IF / REQ_LS
module arb_select
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idle,
    input  logic             if_req,
    input  logic             ls_req,
    output logic [N_REQ-1:0] gnt
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

    always_comb begin
        gnt = '0;
        if (idle) begin
            if (if_req && (!ls_req || starved)) begin
                gnt[REQ_IF] = 1'b1;
            end else if (ls_req) begin
                gnt[REQ_LS] = 1'b1;
            end
        end
    end

    // Counts every cycle fetch is left waiting, including cycles spent
    // behind a busy bus, so a long load/store stream cannot hide it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!if_req || gnt[REQ_IF]) begin
            starve_cnt <= '0;
        end else if (!starved) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-outstanding memory bus arbiter
//
// Purpose: shares one memory bus between instruction fetch (read-only)
// and load/store, one transaction at a time, with a bus timeout abort.
// Ports:
//   clk, reset                  clock and asynchronous active-low reset
//   if_req/if_addr/if_gnt       fetch request side
//   if_rvalid/if_rdata/if_err   fetch response (one-cycle pulse)
//   ls_req/ls_we/ls_addr/ls_wdata/ls_wstrb/ls_gnt   load/store request side
//   ls_rvalid/ls_rdata/ls_err   load/store response (one-cycle pulse)
//   mem_valid/mem_we/mem_addr/mem_wdata/mem_wstrb   bus request, held until mem_ready
//   mem_ready/mem_rdata         bus completion and read data
module mem_arbiter
    import core_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    output logic              if_err,

    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic [XLEN-1:0]   ls_wdata,
    input  logic [STRB_W-1:0] ls_wstrb,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [XLEN-1:0]   ls_rdata,
    output logic              ls_err,

    output logic              mem_valid,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic [N_REQ-1:0] gnt;
    logic             grant_en;
    logic             busy;
    logic             done;
    logic             to_limit;
    logic             abort;
    logic [TO_W-1:0]  to_cnt;

    // Gating with reset keeps every output low while reset is held.
    assign grant_en = (state_q == IDLE) && reset;
    assign busy     = (state_q != IDLE);

    arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk    (clk),
        .reset  (reset),
        .idle   (grant_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .gnt    (gnt)
    );

    assign if_gnt = gnt[REQ_IF];
    assign ls_gnt = gnt[REQ_LS];

    // to_cnt holds the number of completed BUSY cycles without mem_ready,
    // so the limit is hit during the TIMEOUT-th BUSY cycle. A ready in
    // that same cycle still completes normally.
    assign to_limit = (TIMEOUT != 0) && (to_cnt == TO_W'(TIMEOUT - 1));
    assign done     = busy && mem_valid && mem_ready;
    assign abort    = busy && !mem_ready && to_limit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (gnt[REQ_LS]) begin
                    state_d = BUSY_LS;
                end else if (gnt[REQ_IF]) begin
                    state_d = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (done || abort) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Held at zero while idle so every transaction starts from a clean count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (!busy) begin
            to_cnt <= '0;
        end else if (!mem_ready && !to_limit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Bus fields are captured at the grant and stay untouched until the
    // next grant; only mem_valid changes on completion or abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (gnt[REQ_LS]) begin
            mem_valid <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wstrb <= ls_wstrb;
        end else if (gnt[REQ_IF]) begin
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (done || abort) begin
            mem_valid <= 1'b0;
        end
    end

    // Response routing: only the owner of the finished transaction pulses,
    // so the two rvalids are mutually exclusive by construction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            ls_rvalid <= 1'b0;
            ls_rdata  <= '0;
            ls_err    <= 1'b0;
        end else begin
            if_rvalid <= 1'b0;
            ls_rvalid <= 1'b0;
            if (done || abort) begin
                if (state_q == BUSY_IF) begin
                    if_rvalid <= 1'b1;
                    if_err    <= abort;
                    if_rdata  <= done ? mem_rdata : '0;
                end else begin
                    ls_rvalid <= 1'b1;
                    ls_err    <= abort;
                    ls_rdata  <= (done && !mem_we) ? mem_rdata : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wstrb;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wstrb  (ls_wstrb),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] if_addr;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_wstrb;
        logic [31:0] rdata;
        logic        exp_if;
        logic        exp_ls;
        logic        exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk32({tag, "_flags"},
              {24'd0, if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, mem_valid, mem_we},
              32'd0);
        chk32({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk32({tag, "_ls_rdata"}, ls_rdata, 32'd0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk32({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk32({tag, "_mem_wstrb"}, {28'd0, mem_wstrb}, 32'd0);
    endtask

    logic [7:0] sv_if_gnt;
    logic [7:0] sv_ls_gnt;
    logic [7:0] sv_if_rv;
    logic [7:0] sv_ls_rv;
    int         vcnt;
    int         rv_at;

    initial begin
        //           ifr   lsr   we    if_addr       ls_addr       ls_wdata      strb   rdata         e_if  e_ls  e_we  e_addr        e_wdata       e_strb e_rdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        4'h0, 32'h0000_0013, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'h0000_0013};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_2004, 32'h0,        4'h0, 32'hCAFE_0001, 1'b0, 1'b1, 1'b0, 32'h0000_2004, 32'h0,        4'h0, 32'hCAFE_0001};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_2008, 32'h0000_A5A5, 4'h3, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 32'h0000_2008, 32'h0000_A5A5, 4'h3, 32'h0};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0000_3000, 32'h1111_1111, 4'hF, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_0103, 32'h0,        4'h0, 32'h8000_0001};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_5000, 32'h0,        4'h0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'h0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_2010, 32'h0,        4'h0, 32'h0000_000A, 1'b0, 1'b1, 1'b0, 32'h0000_2010, 32'h0,        4'h0, 32'h0000_000A};

        reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = 32'h0;
        ls_wdata  = 32'h0;
        ls_wstrb  = 4'h0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        tick;
        reset = 1'b1;

        // Reset in the middle of a load: bus request drops at once, no response later
        tick;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_4000;
        @(negedge clk);
        chk1("rst_ls_gnt", ls_gnt, 1'b1);
        tick;
        ls_req = 1'b0;
        @(negedge clk);
        chk1("rst_mem_valid_before", mem_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0099;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1("rst_no_ls_rvalid", ls_rvalid, 1'b0);
            chk1("rst_no_mem_valid", mem_valid, 1'b0);
            tick;
        end
        mem_ready = 1'b0;

        // Table-driven single transactions: grant, bus fields, response
        for (int i = 0; i < NV; i++) begin
            tick;
            if_req    = vecs[i].if_req;
            ls_req    = vecs[i].ls_req;
            ls_we     = vecs[i].ls_we;
            if_addr   = vecs[i].if_addr;
            ls_addr   = vecs[i].ls_addr;
            ls_wdata  = vecs[i].ls_wdata;
            ls_wstrb  = vecs[i].ls_wstrb;
            mem_ready = 1'b0;
            @(negedge clk);
            chk1($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].exp_if);
            chk1($sformatf("v%0d_ls_gnt", i), ls_gnt, vecs[i].exp_ls);
            tick;
            if_req    = 1'b0;
            ls_req    = 1'b0;
            mem_ready = 1'b1;
            mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk1($sformatf("v%0d_mem_valid", i), mem_valid, vecs[i].exp_if | vecs[i].exp_ls);
            if (vecs[i].exp_if | vecs[i].exp_ls) begin
                chk1($sformatf("v%0d_mem_we", i), mem_we, vecs[i].exp_we);
                chk32($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].exp_addr);
                chk32($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
                chk32($sformatf("v%0d_mem_wstrb", i), {28'd0, mem_wstrb}, {28'd0, vecs[i].exp_wstrb});
            end
            tick;
            mem_ready = 1'b0;
            @(negedge clk);
            chk1($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].exp_if);
            chk1($sformatf("v%0d_ls_rvalid", i), ls_rvalid, vecs[i].exp_ls);
            chk1($sformatf("v%0d_mem_valid_done", i), mem_valid, 1'b0);
            if (vecs[i].exp_if) begin
                chk32($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].exp_rdata);
                chk1($sformatf("v%0d_if_err", i), if_err, 1'b0);
            end
            if (vecs[i].exp_ls) begin
                chk32($sformatf("v%0d_ls_rdata", i), ls_rdata, vecs[i].exp_rdata);
                chk1($sformatf("v%0d_ls_err", i), ls_err, 1'b0);
            end
        end

        // Starvation: both requesting, bus always ready.
        // Grants: ls, -, ls, -, if (counter hit 4), -, ls (counter cleared), -
        sv_if_gnt = 8'b0001_0000;
        sv_ls_gnt = 8'b0100_0101;
        sv_if_rv  = 8'b0100_0000;
        sv_ls_rv  = 8'b0001_0100;
        tick;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        ls_we     = 1'b0;
        if_addr   = 32'h0000_0400;
        ls_addr   = 32'h0000_3000;
        ls_wstrb  = 4'h0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0077;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick;
            @(negedge clk);
            chk1($sformatf("starve_c%0d_if_gnt", k), if_gnt, sv_if_gnt[k]);
            chk1($sformatf("starve_c%0d_ls_gnt", k), ls_gnt, sv_ls_gnt[k]);
            chk1($sformatf("starve_c%0d_if_rvalid", k), if_rvalid, sv_if_rv[k]);
            chk1($sformatf("starve_c%0d_ls_rvalid", k), ls_rvalid, sv_ls_rv[k]);
            if (k == 5) begin
                chk32("starve_if_mem_addr", mem_addr, 32'h0000_0400);
                chk1("starve_if_mem_we", mem_we, 1'b0);
            end
        end
        tick;
        if_req = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        chk1("starve_tail_ls_rvalid", ls_rvalid, 1'b1);
        chk32("starve_tail_ls_rdata", ls_rdata, 32'h0000_0077);
        tick;
        mem_ready = 1'b0;

        // Timeout: load never answered -> 8 cycles of mem_valid then error response
        tick;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0000_5000;
        @(negedge clk);
        chk1("to_ls_gnt", ls_gnt, 1'b1);
        vcnt  = 0;
        rv_at = -1;
        for (int i = 0; i < 14; i++) begin
            tick;
            ls_req = 1'b0;
            @(negedge clk);
            if (mem_valid) vcnt++;
            if (ls_rvalid && rv_at < 0) begin
                rv_at = i;
                chk1("to_ls_err", ls_err, 1'b1);
                chk32("to_ls_rdata", ls_rdata, 32'h0);
            end
        end
        chk32("to_valid_cycles", vcnt, 32'd8);
        chk32("to_rvalid_cycle", rv_at, 32'd8);
        tick;
        if_req  = 1'b1;
        if_addr = 32'h0000_0600;
        @(negedge clk);
        chk1("to_idle_if_gnt", if_gnt, 1'b1);
        tick;
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0000_0123;
        tick;
        mem_ready = 1'b0;
        @(negedge clk);
        chk1("to_after_if_rvalid", if_rvalid, 1'b1);
        chk32("to_after_if_rdata", if_rdata, 32'h0000_0123);

        // Race: ready arrives in the 8th BUSY cycle -> normal completion
        tick;
        ls_req  = 1'b1;
        ls_addr = 32'h0000_6000;
        @(negedge clk);
        chk1("race_ls_gnt", ls_gnt, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick;
            ls_req    = 1'b0;
            mem_ready = (i == 7);
            mem_rdata = 32'h0000_0055;
            @(negedge clk);
            chk1($sformatf("race_c%0d_mem_valid", i + 1), mem_valid, 1'b1);
            chk1($sformatf("race_c%0d_ls_rvalid", i + 1), ls_rvalid, 1'b0);
        end
        tick;
        mem_ready = 1'b0;
        @(negedge clk);
        chk1("race_ls_rvalid", ls_rvalid, 1'b1);
        chk1("race_ls_err", ls_err, 1'b0);
        chk32("race_ls_rdata", ls_rdata, 32'h0000_0055);
        chk1("race_mem_valid_low", mem_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
